// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: match sequencer (state machine, ball-step enable, speed, scores, sound).
// Optional attract mode in IDLE is enabled by defining PONG_ATTRACT_EN.
`default_nettype none

module pong_match_ctrl #(
  parameter int FRAMES_SERVE = 60,
  parameter int FRAMES_GOAL  = 90,
  parameter int WIN_SCORE    = 9,
  parameter int SND_FRAMES   = 6,
  parameter int SPEED_INIT   = 4,
  parameter int SPEED_MIN    = 1,
  parameter int SPEED_MAX    = 8
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       inc_vel,
  input  logic       dec_vel,
  input  logic       goal_left,
  input  logic       goal_right,
  input  logic       hit_paddle,
  input  logic       hit_wall,
  output logic       ball_step,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [3:0] speed,
  output logic [1:0] winner,
  output logic       mute,
  output logic [1:0] code_sound
);

  localparam int FMAX = (FRAMES_SERVE > FRAMES_GOAL) ? FRAMES_SERVE : FRAMES_GOAL;
  localparam int FW   = $clog2(FMAX + 1);
  localparam int SW   = $clog2(SND_FRAMES + 1);

  localparam logic [FW-1:0] C_FR_SERVE = FW'(FRAMES_SERVE);
  localparam logic [FW-1:0] C_FR_GOAL  = FW'(FRAMES_GOAL);
  localparam logic [SW-1:0] C_SND      = SW'(SND_FRAMES);
  localparam logic [3:0]    C_SP_INIT  = 4'(SPEED_INIT);
  localparam logic [3:0]    C_SP_MIN   = 4'(SPEED_MIN);
  localparam logic [3:0]    C_SP_MAX   = 4'(SPEED_MAX);
  localparam logic [4:0]    C_SP_MAX5  = 5'(SPEED_MAX);
  localparam logic [3:0]    C_WIN      = 4'(WIN_SCORE);

  localparam logic [1:0] SND_STOP = 2'b00;
  localparam logic [1:0] SND_PING = 2'b10;
  localparam logic [1:0] SND_PONG = 2'b01;
  localparam logic [1:0] SND_GO   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_GOAL  = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t        state_q;
  logic [FW-1:0] frame_q;
  logic [SW-1:0] snd_q;
  logic [3:0]    acc_q, speed_q, score1_q, score2_q;
  logic [1:0]    winner_q, code_q;
  logic          serve_dir_q, ball_step_q, ball_reset_q, mute_q;

  logic       run_state, step_d, start_now, goal_now, snd_load;
  logic [4:0] sum;
  logic [3:0] acc_d, speed_d;
  logic [1:0] ev_code, ev_prio, cur_prio;

  always_comb begin
`ifdef PONG_ATTRACT_EN
    run_state = (state_q == S_PLAY) || (state_q == S_IDLE);
`else
    run_state = (state_q == S_PLAY);
`endif
    sum    = {1'b0, acc_q} + {1'b0, speed_q};
    step_d = frame_tick && run_state && (sum >= C_SP_MAX5);
    acc_d  = acc_q;
    if (frame_tick && run_state) begin
      acc_d = step_d ? 4'(sum - C_SP_MAX5) : sum[3:0];
    end

    speed_d = speed_q;
    if (inc_vel && !dec_vel && (speed_q < C_SP_MAX)) begin
      speed_d = speed_q + 4'd1;
    end else if (dec_vel && !inc_vel && (speed_q > C_SP_MIN)) begin
      speed_d = speed_q - 4'd1;
    end

    start_now = start && ((state_q == S_IDLE) || (state_q == S_OVER));
    goal_now  = (goal_left || goal_right) && (state_q == S_PLAY);

    // Arbitration ranks: go=3, pong=2, ping=1, silence=0.
    ev_code = SND_STOP;
    ev_prio = 2'd0;
    if (start_now || goal_now) begin
      ev_code = SND_GO;
      ev_prio = 2'd3;
    end else if (hit_paddle && (state_q == S_PLAY)) begin
      ev_code = SND_PONG;
      ev_prio = 2'd2;
    end else if (hit_wall && (state_q == S_PLAY)) begin
      ev_code = SND_PING;
      ev_prio = 2'd1;
    end

    case (code_q)
      SND_GO:   cur_prio = 2'd3;
      SND_PONG: cur_prio = 2'd2;
      SND_PING: cur_prio = 2'd1;
      default:  cur_prio = 2'd0;
    endcase
    snd_load = (ev_prio != 2'd0) && (ev_prio >= cur_prio);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q      <= S_IDLE;
      frame_q      <= '0;
      snd_q        <= '0;
      acc_q        <= 4'd0;
      speed_q      <= C_SP_INIT;
      score1_q     <= 4'd0;
      score2_q     <= 4'd0;
      winner_q     <= 2'b00;
      serve_dir_q  <= 1'b0;
      ball_step_q  <= 1'b0;
      ball_reset_q <= 1'b0;
      mute_q       <= 1'b1;
      code_q       <= SND_STOP;
    end else begin
      ball_step_q  <= step_d;
      ball_reset_q <= 1'b0;
      acc_q        <= acc_d;
      speed_q      <= speed_d;

      if (snd_load) begin
        code_q <= ev_code;
        mute_q <= 1'b0;
        snd_q  <= C_SND;
      end else if (frame_tick && (snd_q != '0)) begin
        snd_q <= snd_q - 1'b1;
        if (snd_q == SW'(1)) begin
          mute_q <= 1'b1;
          code_q <= SND_STOP;
        end
      end

      if (start_now) begin
        state_q      <= S_SERVE;
        frame_q      <= C_FR_SERVE;
        score1_q     <= 4'd0;
        score2_q     <= 4'd0;
        winner_q     <= 2'b00;
        speed_q      <= C_SP_INIT;
        acc_q        <= 4'd0;
        ball_reset_q <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
`ifdef PONG_ATTRACT_EN
            if (goal_left || goal_right) begin
              ball_reset_q <= 1'b1;
            end
`endif
          end
          S_SERVE: begin
            if (frame_tick) begin
              frame_q <= frame_q - 1'b1;
              if (frame_q <= FW'(1)) begin
                state_q <= S_PLAY;
              end
            end
          end
          S_PLAY: begin
            // goal_left has precedence when both sides report in one cycle.
            if (goal_left) begin
              if (score2_q < C_WIN) score2_q <= score2_q + 4'd1;
              serve_dir_q <= 1'b0;
              state_q     <= S_GOAL;
              frame_q     <= C_FR_GOAL;
            end else if (goal_right) begin
              if (score1_q < C_WIN) score1_q <= score1_q + 4'd1;
              serve_dir_q <= 1'b1;
              state_q     <= S_GOAL;
              frame_q     <= C_FR_GOAL;
            end
          end
          S_GOAL: begin
            if (frame_tick) begin
              frame_q <= frame_q - 1'b1;
              if (frame_q <= FW'(1)) begin
                if ((score1_q == C_WIN) || (score2_q == C_WIN)) begin
                  state_q  <= S_OVER;
                  winner_q <= (score1_q == C_WIN) ? 2'b01 : 2'b10;
                end else begin
                  state_q      <= S_SERVE;
                  frame_q      <= C_FR_SERVE;
                  ball_reset_q <= 1'b1;
                end
              end
            end
          end
          S_OVER: begin
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign ball_step  = ball_step_q;
  assign ball_reset = ball_reset_q;
  assign serve_dir  = serve_dir_q;
  assign score1     = score1_q;
  assign score2     = score2_q;
  assign speed      = speed_q;
  assign winner     = winner_q;
  assign mute       = mute_q;
  assign code_sound = code_q;

endmodule

`default_nettype wire

// File: tb/tb_pong_match_ctrl.sv
// Directed self-checking bench for pong_match_ctrl (default parameters).
`default_nettype none

module tb_pong_match_ctrl;

  logic clk = 1'b0;
  logic clr_n = 1'b0;
  logic frame_tick = 1'b0, start = 1'b0, inc_vel = 1'b0, dec_vel = 1'b0;
  logic goal_left = 1'b0, goal_right = 1'b0, hit_paddle = 1'b0, hit_wall = 1'b0;
  logic       ball_step, ball_reset, serve_dir, mute;
  logic [3:0] score1, score2, speed;
  logic [1:0] winner, code_sound;

  int checks = 0;
  int errors = 0;
  int steps  = 0;
  int resets = 0;

  pong_match_ctrl dut (
    .clk(clk), .clr_n(clr_n), .frame_tick(frame_tick), .start(start),
    .inc_vel(inc_vel), .dec_vel(dec_vel), .goal_left(goal_left), .goal_right(goal_right),
    .hit_paddle(hit_paddle), .hit_wall(hit_wall), .ball_step(ball_step),
    .ball_reset(ball_reset), .serve_dir(serve_dir), .score1(score1), .score2(score2),
    .speed(speed), .winner(winner), .mute(mute), .code_sound(code_sound)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One frame: tick high for one cycle, low for one; tallies step/reset pulses seen.
  task automatic tick();
    frame_tick = 1'b1;
    cyc();
    steps  += int'(ball_step);
    resets += int'(ball_reset);
    frame_tick = 1'b0;
    cyc();
    steps  += int'(ball_step);
    resets += int'(ball_reset);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  function automatic logic [7:0] st();
    return 8'(dut.state_q);
  endfunction

  initial begin
    repeat (2) cyc();
    chk("rst_score1", 8'(score1), 8'd0);
    chk("rst_score2", 8'(score2), 8'd0);
    chk("rst_speed", 8'(speed), 8'd4);
    chk("rst_winner", 8'(winner), 8'd0);
    chk("rst_mute", 8'(mute), 8'd1);
    chk("rst_code", 8'(code_sound), 8'd0);
    chk("rst_step", 8'(ball_step), 8'd0);
    chk("rst_breset", 8'(ball_reset), 8'd0);
    chk("rst_dir", 8'(serve_dir), 8'd0);
    clr_n = 1'b1;
    cyc();

    goal_left = 1'b1; cyc(); goal_left = 1'b0;
    chk("idle_goal_ignored", 8'(score2), 8'd0);

    start = 1'b1; cyc(); start = 1'b0;
    chk("start_breset", 8'(ball_reset), 8'd1);
    chk("start_go", 8'(code_sound), 8'd3);
    chk("start_unmute", 8'(mute), 8'd0);
    chk("start_serve", st(), 8'd1);
    cyc();
    chk("breset_one_cycle", 8'(ball_reset), 8'd0);

    steps = 0; resets = 0;
    ticks(5);
    chk("go_held_5", 8'(mute), 8'd0);
    tick();
    chk("go_mute_6", 8'(mute), 8'd1);
    chk("go_code_6", 8'(code_sound), 8'd0);
    ticks(53);
    chk("serve_59", st(), 8'd1);
    tick();
    chk("play_60", st(), 8'd2);
    chk("serve_no_step", 8'(steps), 8'd0);
    tick();
    chk("play_f1_step", 8'(steps), 8'd0);
    tick();
    chk("play_f2_step", 8'(steps), 8'd1);

    steps = 0;
    ticks(16);
    chk("speed4_16f", 8'(steps), 8'd8);

    repeat (4) begin inc_vel = 1'b1; cyc(); inc_vel = 1'b0; cyc(); end
    chk("speed_inc4", 8'(speed), 8'd8);
    repeat (2) begin inc_vel = 1'b1; cyc(); inc_vel = 1'b0; cyc(); end
    chk("speed_sat_max", 8'(speed), 8'd8);
    steps = 0;
    ticks(4);
    chk("speed8_4f", 8'(steps), 8'd4);
    dec_vel = 1'b1; cyc(); dec_vel = 1'b0;
    chk("speed_dec", 8'(speed), 8'd7);
    dec_vel = 1'b1; inc_vel = 1'b1; cyc(); dec_vel = 1'b0; inc_vel = 1'b0;
    chk("speed_both", 8'(speed), 8'd7);
    inc_vel = 1'b1; cyc(); inc_vel = 1'b0;
    chk("speed_back8", 8'(speed), 8'd8);

    hit_wall = 1'b1; cyc(); hit_wall = 1'b0;
    chk("ping_code", 8'(code_sound), 8'd2);
    chk("ping_unmute", 8'(mute), 8'd0);
    ticks(2);
    hit_paddle = 1'b1; cyc(); hit_paddle = 1'b0;
    chk("pong_code", 8'(code_sound), 8'd1);
    hit_wall = 1'b1; cyc(); hit_wall = 1'b0;
    chk("ping_during_pong", 8'(code_sound), 8'd1);
    ticks(5);
    chk("pong_reloaded", 8'(mute), 8'd0);
    tick();
    chk("pong_expired_mute", 8'(mute), 8'd1);
    chk("pong_expired_code", 8'(code_sound), 8'd0);

    goal_right = 1'b1; cyc(); goal_right = 1'b0;
    chk("gr_score1", 8'(score1), 8'd1);
    chk("gr_dir", 8'(serve_dir), 8'd1);
    chk("gr_goal_state", st(), 8'd3);
    chk("gr_go", 8'(code_sound), 8'd3);
    goal_left = 1'b1; cyc(); goal_left = 1'b0;
    chk("goal_in_goal_ignored", 8'(score2), 8'd0);
    steps = 0; resets = 0;
    ticks(89);
    chk("goal_89", st(), 8'd3);
    tick();
    chk("goal_90_serve", st(), 8'd1);
    chk("goal_breset", 8'(resets), 8'd1);
    chk("goal_no_step", 8'(steps), 8'd0);
    ticks(60);
    chk("serve2_play", st(), 8'd2);

    goal_left = 1'b1; goal_right = 1'b1; cyc(); goal_left = 1'b0; goal_right = 1'b0;
    chk("both_score2", 8'(score2), 8'd1);
    chk("both_score1", 8'(score1), 8'd1);
    chk("both_dir", 8'(serve_dir), 8'd0);
    ticks(90);
    chk("both_serve", st(), 8'd1);

    repeat (8) begin
      ticks(60);
      goal_right = 1'b1; cyc(); goal_right = 1'b0;
      ticks(90);
    end
    chk("win_score1", 8'(score1), 8'd9);
    chk("win_score2", 8'(score2), 8'd1);
    chk("win_over", st(), 8'd4);
    chk("win_winner", 8'(winner), 8'd1);

    repeat (8) begin dec_vel = 1'b1; cyc(); dec_vel = 1'b0; cyc(); end
    chk("speed_sat_min", 8'(speed), 8'd1);

    start = 1'b1; cyc(); start = 1'b0;
    chk("restart_score1", 8'(score1), 8'd0);
    chk("restart_score2", 8'(score2), 8'd0);
    chk("restart_speed", 8'(speed), 8'd4);
    chk("restart_winner", 8'(winner), 8'd0);
    chk("restart_breset", 8'(ball_reset), 8'd1);
    chk("restart_serve", st(), 8'd1);
    ticks(60);
    chk("restart_play", st(), 8'd2);

    hit_paddle = 1'b1; inc_vel = 1'b1; cyc(); hit_paddle = 1'b0; inc_vel = 1'b0;
    chk("pre_rst_speed", 8'(speed), 8'd5);
    chk("pre_rst_code", 8'(code_sound), 8'd1);
    #2;
    clr_n = 1'b0;
    #1;
    chk("async_speed", 8'(speed), 8'd4);
    chk("async_code", 8'(code_sound), 8'd0);
    chk("async_mute", 8'(mute), 8'd1);
    chk("async_dir", 8'(serve_dir), 8'd0);
    chk("async_state", st(), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
